// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives a word-wide req/ack data-memory bus,
// stalls the pipeline for the access and returns aligned, extended load data.
module mem_access_unit #(
  parameter int ACK_IGNORE_IDLE = 1,
  parameter int L_S_MODE_W      = 3,
  parameter logic [L_S_MODE_W-1:0] L_S_BYTE   = L_S_MODE_W'(0),
  parameter logic [L_S_MODE_W-1:0] L_S_BYTE_U = L_S_MODE_W'(1),
  parameter logic [L_S_MODE_W-1:0] L_S_HALF   = L_S_MODE_W'(2),
  parameter logic [L_S_MODE_W-1:0] L_S_HALF_U = L_S_MODE_W'(3),
  parameter logic [L_S_MODE_W-1:0] L_S_WORD   = L_S_MODE_W'(4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [L_S_MODE_W-1:0] l_s_mode,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [31:0]           dm_addr,
  output logic [3:0]            dm_be,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_ack,
  input  logic [31:0]           dm_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Unknown modes fall through to word size.
  function automatic logic [1:0] f_size(input logic [L_S_MODE_W-1:0] mode);
    logic [1:0] sz;
    sz = SZ_WORD;
    if (mode == L_S_BYTE || mode == L_S_BYTE_U) sz = SZ_BYTE;
    else if (mode == L_S_HALF || mode == L_S_HALF_U) sz = SZ_HALF;
    return sz;
  endfunction

  function automatic logic f_aligned(input logic [1:0] sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] f_store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] f_load(input logic [L_S_MODE_W-1:0] mode,
                                         input logic [1:0] off,
                                         input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = off[1] ? raw[31:16] : raw[15:0];
    if (mode == L_S_BYTE)        r = {{24{b[7]}}, b};
    else if (mode == L_S_BYTE_U) r = {24'd0, b};
    else if (mode == L_S_HALF)   r = {{16{h[15]}}, h};
    else if (mode == L_S_HALF_U) r = {16'd0, h};
    else                         r = raw;
    return r;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_req;
  logic                    w_aligned;
  logic                    w_accept;
  logic                    w_stall;
  logic                    w_misalign;
  logic                    w_rdata_valid;
  logic [1:0]              w_size;

  logic                    r_rd;
  logic [L_S_MODE_W-1:0]   r_mode;
  logic [1:0]              r_off;
  logic                    r_dm_req;
  logic                    r_dm_we;
  logic [31:0]             r_dm_addr;
  logic [3:0]              r_dm_be;
  logic [31:0]             r_dm_wdata;
  logic [31:0]             r_rdata;
  logic                    r_ack_d;
  logic                    r_bus_err;

  assign w_req     = mem_read_en | mem_write_en;
  assign w_size    = f_size(l_s_mode);
  assign w_aligned = f_aligned(w_size, addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_stall       = 1'b0;
    w_misalign    = 1'b0;
    w_rdata_valid = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_aligned) begin
            w_stall     = 1'b1;
            w_accept    = 1'b1;
            w_state_nxt = S_BUS;
          end else begin
            w_misalign  = 1'b1;
          end
        end
      end
      S_BUS: begin
        w_stall = 1'b1;
        if (dm_ack) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // Requests are deliberately not looked at here: the instruction
        // that caused this access is still presented until DONE ends.
        w_rdata_valid = r_rd;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd       <= 1'b0;
      r_mode     <= '0;
      r_off      <= 2'b00;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= 32'd0;
      r_dm_be    <= 4'd0;
      r_dm_wdata <= 32'd0;
      r_rdata    <= 32'd0;
      r_ack_d    <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_ack_d   <= dm_ack;
      // Only the first cycle of an ack outside BUS is unexpected; an ack held
      // over from a completed access is not.
      r_bus_err <= (ACK_IGNORE_IDLE == 0) && (r_state != S_BUS) && dm_ack && !r_ack_d;
      if (w_accept) begin
        r_rd       <= mem_read_en;
        r_mode     <= l_s_mode;
        r_off      <= addr[1:0];
        r_dm_req   <= 1'b1;
        r_dm_we    <= mem_write_en & ~mem_read_en;
        r_dm_addr  <= {addr[31:2], 2'b00};
        r_dm_be    <= f_be(w_size, addr[1:0]);
        r_dm_wdata <= mem_read_en ? 32'd0 : f_store_data(w_size, wdata);
      end else if (r_state == S_BUS && dm_ack) begin
        r_dm_req <= 1'b0;
        if (r_rd) r_rdata <= f_load(r_mode, r_off, dm_rdata);
      end
    end
  end

  assign stall       = w_stall & ~rst;
  assign misalign    = w_misalign & ~rst;
  assign rdata_valid = w_rdata_valid & ~rst;
  assign rdata       = r_rdata;
  assign bus_err     = r_bus_err;
  assign dm_req      = r_dm_req;
  assign dm_we       = r_dm_we;
  assign dm_addr     = r_dm_addr;
  assign dm_be       = r_dm_be;
  assign dm_wdata    = r_dm_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random ops against a
// byte-array memory model, and hand sequences for reset/ack corner cases.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  l_s_mode;
  logic [31:0] addr, wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        stall, rdata_valid, misalign, bus_err, dm_req, dm_we;
  logic [31:0] rdata, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  logic        stall_b, rdata_valid_b, misalign_b, bus_err_b, dm_req_b, dm_we_b;
  logic [31:0] rdata_b, dm_addr_b, dm_wdata_b;
  logic [3:0]  dm_be_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit u_dut (
    .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .l_s_mode(l_s_mode), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .misalign(misalign), .bus_err(bus_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  mem_access_unit #(.ACK_IGNORE_IDLE(0)) u_dut_err (
    .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .l_s_mode(l_s_mode), .addr(addr), .wdata(wdata), .stall(stall_b), .rdata(rdata_b),
    .rdata_valid(rdata_valid_b), .misalign(misalign_b), .bus_err(bus_err_b), .dm_req(dm_req_b),
    .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_be(dm_be_b), .dm_wdata(dm_wdata_b),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          waits;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] dwd;
    logic [31:0] rdata;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  bmem[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] mode,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                              input int waits, input logic mis, input logic [3:0] be,
                              input logic [31:0] dwd, input logic [31:0] rdv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mode = mode; v.addr = a; v.wdata = wd; v.rword = rw;
    v.waits = waits; v.mis = mis; v.be = be; v.dwd = dwd; v.rdata = rdv;
    return v;
  endfunction

  // Reference model: byte-addressed memory, access size in bytes.
  function automatic int size_of(input logic [2:0] mode);
    if (mode <= 3'd1) return 1;
    if (mode <= 3'd3) return 2;
    return 4;
  endfunction

  function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] mode,
                                 input logic [31:0] a, input logic [31:0] wd, input int waits);
    vec_t v;
    int sz;
    int base;
    logic [31:0] val;
    sz = size_of(mode);
    v = mk(rd, wr, mode, a, wd, 32'd0, waits, 1'b0, 4'd0, 32'd0, 32'd0);
    v.mis = ((a % sz) != 0);
    base = int'(a[7:0]) & ~3;
    for (int k = 0; k < 4; k++) v.rword[8*k +: 8] = bmem[base + k];
    for (int i = 0; i < sz; i++) v.be[int'(a[1:0]) + i] = 1'b1;
    if (!rd)
      for (int k = 0; k < 4; k++) v.dwd[8*k +: 8] = wd[8*(k % sz) +: 8];
    val = 32'd0;
    for (int i = 0; i < sz; i++) val[8*i +: 8] = bmem[(int'(a[7:0]) + i) & 255];
    if ((mode == 3'd0 || mode == 3'd2) && val[8*sz-1]) val = val | (32'hFFFFFFFF << (8*sz));
    v.rdata = val;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_read_en = 1'b0; mem_write_en = 1'b0; l_s_mode = 3'd0; addr = 32'd0; wdata = 32'd0;
  endtask

  // Starts in an IDLE cycle just after a negedge; returns likewise.
  task automatic xact(input vec_t v, input string tag);
    int nstall;
    mem_read_en = v.rd; mem_write_en = v.wr; l_s_mode = v.mode; addr = v.addr; wdata = v.wdata;
    #1;
    if (v.mis) begin
      chk({tag, ".misalign"}, {31'd0, misalign}, 32'd1);
      chk({tag, ".mis_stall"}, {31'd0, stall}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk({tag, ".mis_no_req"}, {31'd0, dm_req}, 32'd0);
      chk({tag, ".mis_pulse_end"}, {31'd0, misalign}, 32'd0);
      return;
    end
    chk({tag, ".misalign0"}, {31'd0, misalign}, 32'd0);
    nstall = int'(stall);
    @(negedge clk); #1;
    chk({tag, ".req"}, {31'd0, dm_req}, 32'd1);
    chk({tag, ".addr"}, dm_addr, {v.addr[31:2], 2'b00});
    chk({tag, ".we"}, {31'd0, dm_we}, {31'd0, v.wr & ~v.rd});
    chk({tag, ".be"}, {28'd0, dm_be}, {28'd0, v.be});
    chk({tag, ".wdata"}, dm_wdata, v.dwd);
    for (int i = 0; i < v.waits; i++) begin
      nstall += int'(stall);
      @(negedge clk); #1;
    end
    chk({tag, ".req_at_ack"}, {31'd0, dm_req}, 32'd1);
    dm_ack = 1'b1; dm_rdata = v.rword;
    nstall += int'(stall);
    @(negedge clk);
    dm_ack = 1'b0; dm_rdata = $urandom;
    #1;
    nstall += int'(stall);
    chk({tag, ".done_req"}, {31'd0, dm_req}, 32'd0);
    chk({tag, ".rvalid"}, {31'd0, rdata_valid}, {31'd0, v.rd});
    if (v.rd) chk({tag, ".rdata"}, rdata, v.rdata);
    chk({tag, ".stall_cycles"}, nstall, v.waits + 2);
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, ".no_reissue"}, {30'd0, dm_req, stall}, 32'd0);
    chk({tag, ".rvalid_end"}, {31'd0, rdata_valid}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   op;
    logic [31:0] a;

    // LB=0 LBU=1 LH=2 LHU=3 LW=4, 7 = unknown (treated as word)
    tbl.push_back(mk(0, 1, 3'd4, 32'h104, 32'hDEADBEEF, 0, 2, 0, 4'b1111, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(0, 1, 3'd2, 32'h102, 32'h1234ABCD, 0, 1, 0, 4'b1100, 32'hABCDABCD, 0));
    tbl.push_back(mk(0, 1, 3'd1, 32'h001, 32'h00000077, 0, 0, 0, 4'b0010, 32'h77777777, 0));
    tbl.push_back(mk(1, 0, 3'd0, 32'h203, 0, 32'h80FF7F01, 0, 0, 4'b1000, 0, 32'hFFFFFF80));
    tbl.push_back(mk(1, 0, 3'd1, 32'h203, 0, 32'h80FF7F01, 1, 0, 4'b1000, 0, 32'h00000080));
    tbl.push_back(mk(1, 0, 3'd2, 32'h202, 0, 32'h80FF7F01, 0, 0, 4'b1100, 0, 32'hFFFF80FF));
    tbl.push_back(mk(1, 0, 3'd3, 32'h200, 0, 32'h80FF7F01, 3, 0, 4'b0011, 0, 32'h00007F01));
    tbl.push_back(mk(1, 0, 3'd4, 32'h200, 0, 32'h80FF7F01, 0, 0, 4'b1111, 0, 32'h80FF7F01));
    tbl.push_back(mk(1, 0, 3'd0, 32'h201, 0, 32'h80FF7F01, 0, 0, 4'b0010, 0, 32'h0000007F));
    tbl.push_back(mk(1, 0, 3'd4, 32'h102, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd2, 32'h101, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd4, 32'h001, 32'h11223344, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd7, 32'h302, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3'd7, 32'h300, 0, 32'h8000ABCD, 0, 0, 4'b1111, 0, 32'h8000ABCD));
    tbl.push_back(mk(1, 1, 3'd4, 32'h300, 32'h11111111, 32'hCAFEF00D, 1, 0, 4'b1111, 0, 32'hCAFEF00D));

    // Reset with a request pending on the inputs
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'd0; idle_inputs();
    mem_read_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.stall_in_reset", {31'd0, stall}, 32'd0);
    rst = 1'b0; idle_inputs();
    #1;
    chk("rst.dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst.dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst.dm_addr", dm_addr, 32'd0);
    chk("rst.dm_be", {28'd0, dm_be}, 32'd0);
    chk("rst.dm_wdata", dm_wdata, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.flags", {28'd0, stall, rdata_valid, misalign, bus_err}, 32'd0);
    chk("rst.bus_err_b", {31'd0, bus_err_b}, 32'd0);

    foreach (tbl[i]) xact(tbl[i], $sformatf("tbl%0d", i));

    // Reset while in BUS, then a late ack lands in IDLE
    v = mk(1, 0, 3'd4, 32'h40, 0, 0, 0, 0, 4'b1111, 0, 0);
    mem_read_en = 1'b1; l_s_mode = 3'd4; addr = 32'h40;
    @(negedge clk); #1;
    chk("rstbus.req", {31'd0, dm_req}, 32'd1);
    rst = 1'b1; idle_inputs();
    @(negedge clk);
    rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h12345678;
    #1;
    chk("rstbus.req_cleared", {31'd0, dm_req}, 32'd0);
    chk("rstbus.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    chk("rstbus.no_rvalid", {30'd0, rdata_valid, rdata_valid_b}, 32'd0);
    chk("rstbus.bus_err_dflt", {31'd0, bus_err}, 32'd0);
    chk("rstbus.bus_err_strict", {31'd0, bus_err_b}, 32'd1);
    chk("rstbus.rdata_kept", rdata, 32'd0);
    @(negedge clk); #1;
    chk("rstbus.bus_err_pulse", {31'd0, bus_err_b}, 32'd0);

    // Ack held high from BUS through DONE and into IDLE: one completion only
    mem_read_en = 1'b1; l_s_mode = 3'd3; addr = 32'h52;
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'hBEEF0000;
    @(negedge clk); #1;
    chk("heldack.rvalid", {31'd0, rdata_valid}, 32'd1);
    chk("heldack.rdata", rdata, 32'h0000BEEF);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("heldack.idle", {29'd0, dm_req, stall, rdata_valid}, 32'd0);
    @(negedge clk); #1;
    chk("heldack.no_err", {30'd0, bus_err_b, bus_err}, 32'd0);
    dm_ack = 1'b0;
    @(negedge clk); #1;

    // Randomized ops against the byte-array model
    for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 2);
      a  = {$urandom_range(0, 15) << 8, 8'($urandom)};
      v  = model(op != 1, op != 0, 3'($urandom_range(0, 5)), a, $urandom, $urandom_range(0, 3));
      xact(v, $sformatf("rnd%0d", n));
      if (!v.mis && v.wr && !v.rd)
        for (int k = 0; k < size_of(v.mode); k++)
          bmem[(int'(v.addr[7:0]) + k) & 255] = v.wdata[8*k +: 8];
      chk($sformatf("rnd%0d.bus_err", n), {30'd0, bus_err_b, bus_err}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
